// File: rtl/lcd_phy_if.sv
// Byte handshake from the LCD-write command decoder into the i8080 PHY.
// The upstream side holds the byte while valid is high; ready is registered on the PHY side.
interface lcd_phy_if;
  logic [7:0] phy_data;
  logic       phy_rs;
  logic       phy_valid;
  logic       phy_ready;

  modport master (output phy_data, phy_rs, phy_valid, input phy_ready);
  modport slave  (input phy_data, phy_rs, phy_valid, output phy_ready);
endinterface

// File: rtl/lcd_phy_i8080.sv
// 8-bit i8080 write PHY: each accepted byte becomes a timed wr_n strobe, with cs_n idle release.
// First wr_n low T_CSS+1 cycles after accept from OFF, 1 cycle from IDLE; ready low while a write is in flight.
module lcd_phy_i8080 #(
  parameter int T_CSS   = 1,
  parameter int T_WRL   = 2,
  parameter int T_WRH   = 2,
  parameter int CS_IDLE = 15
) (
  input  logic       clk,
  input  logic       rst,
  lcd_phy_if.slave   phy,
  input  logic       i_ctl_lcd_rst,
  output logic       o_stat_busy,
  output logic [7:0] o_lcd_d,
  output logic       o_lcd_rs,
  output logic       o_lcd_wr_n,
  output logic       o_lcd_cs_n,
  output logic       o_lcd_rst_n
);

  typedef enum logic [2:0] {S_OFF, S_SETUP, S_WRL, S_WRH, S_IDLE} state_t;

  localparam logic [3:0] L_CSS  = 4'(T_CSS - 1);
  localparam logic [3:0] L_WRL  = 4'(T_WRL - 1);
  localparam logic [3:0] L_WRH  = 4'(T_WRH - 1);
  localparam logic [7:0] L_IDLE = 8'(CS_IDLE - 1);
  localparam bit         CS_TIMEOUT = (CS_IDLE != 0);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_phase, w_phase_nxt;
  logic [7:0] r_idle_cnt, w_idle_nxt;
  logic       r_ready, r_busy, r_wr_n, r_cs_n, r_rs, r_rst_n;
  logic [7:0] r_d;
  logic       w_accept;

  assign w_accept      = phy.phy_valid & r_ready;
  assign phy.phy_ready = r_ready;
  assign o_stat_busy   = r_busy;
  assign o_lcd_d       = r_d;
  assign o_lcd_rs      = r_rs;
  assign o_lcd_wr_n    = r_wr_n;
  assign o_lcd_cs_n    = r_cs_n;
  assign o_lcd_rst_n   = r_rst_n;

  // Phase counter is loaded with (length-1) on state entry and the state advances when it hits 0.
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_idle_nxt  = r_idle_cnt;
    case (r_state)
      S_OFF: begin
        if (w_accept) begin
          w_state_nxt = S_SETUP;
          w_phase_nxt = L_CSS;
          w_idle_nxt  = '0;
        end
      end
      S_SETUP: begin
        if (r_phase == 4'd0) begin
          w_state_nxt = S_WRL;
          w_phase_nxt = L_WRL;
        end else begin
          w_phase_nxt = r_phase - 4'd1;
        end
      end
      S_WRL: begin
        if (r_phase == 4'd0) begin
          w_state_nxt = S_WRH;
          w_phase_nxt = L_WRH;
        end else begin
          w_phase_nxt = r_phase - 4'd1;
        end
      end
      S_WRH: begin
        if (r_phase == 4'd0) begin
          w_state_nxt = S_IDLE;
          w_idle_nxt  = '0;
        end else begin
          w_phase_nxt = r_phase - 4'd1;
        end
      end
      S_IDLE: begin
        // A byte arriving on the expiry cycle takes priority, so cs_n never glitches high.
        if (w_accept) begin
          w_state_nxt = S_WRL;
          w_phase_nxt = L_WRL;
          w_idle_nxt  = '0;
        end else if (CS_TIMEOUT && r_idle_cnt == L_IDLE) begin
          w_state_nxt = S_OFF;
        end else if (r_idle_cnt != 8'hFF) begin
          w_idle_nxt = r_idle_cnt + 8'd1;
        end
      end
      default: w_state_nxt = S_OFF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_OFF;
      r_phase    <= '0;
      r_idle_cnt <= '0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_wr_n     <= 1'b1;
      r_cs_n     <= 1'b1;
      r_d        <= '0;
      r_rs       <= 1'b0;
      r_rst_n    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_phase    <= w_phase_nxt;
      r_idle_cnt <= w_idle_nxt;
      r_ready    <= (w_state_nxt == S_OFF) || (w_state_nxt == S_IDLE);
      r_busy     <= (w_state_nxt == S_SETUP) || (w_state_nxt == S_WRL) || (w_state_nxt == S_WRH);
      r_wr_n     <= (w_state_nxt != S_WRL);
      r_cs_n     <= (w_state_nxt == S_OFF);
      r_rst_n    <= ~i_ctl_lcd_rst;
      if (w_accept) begin
        r_d  <= phy.phy_data;
        r_rs <= phy.phy_rs;
      end
    end
  end

endmodule

// File: tb/tb_lcd_phy_i8080.sv
// Bench for lcd_phy_i8080: timestamp-based reference model checked every cycle, plus directed literal checks.
module tb_lcd_phy_i8080;
  localparam int P_CSS  = 1;
  localparam int P_WRL  = 2;
  localparam int P_WRH  = 2;
  localparam int P_IDLE = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ctl = 1'b0;
  logic       busy, wr_n, cs_n, lrs, rst_n, ready;
  logic [7:0] d;
  int         n_cmp = 0;
  int         n_bad = 0;

  lcd_phy_if phy_if();
  assign ready = phy_if.phy_ready;

  lcd_phy_i8080 #(.T_CSS(P_CSS), .T_WRL(P_WRL), .T_WRH(P_WRH), .CS_IDLE(P_IDLE)) dut (
    .clk          (clk),
    .rst          (rst),
    .phy          (phy_if),
    .i_ctl_lcd_rst(ctl),
    .o_stat_busy  (busy),
    .o_lcd_d      (d),
    .o_lcd_rs     (lrs),
    .o_lcd_wr_n   (wr_n),
    .o_lcd_cs_n   (cs_n),
    .o_lcd_rst_n  (rst_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Model: interval n is the clock period following edge n; each accepted byte is described
  // by its accept edge, first wr_n-low interval and first idle interval.
  bit         m_rst = 1'b1;
  bit         have_acc = 1'b0;
  int         cyc = 0, t_acc = 0, t_wl = 0, t_idle = 0;
  logic [7:0] m_d = 8'h00;
  logic       m_rs = 1'b0, m_rstn = 1'b0;

  function automatic logic e_busy(int n);
    return !m_rst && have_acc && n >= t_acc && n < t_idle;
  endfunction
  function automatic logic e_ready(int n);
    return !m_rst && !e_busy(n);
  endfunction
  function automatic logic e_wr_n(int n);
    return m_rst || !have_acc || n < t_wl || n >= t_wl + P_WRL;
  endfunction
  function automatic logic e_cs_n(int n);
    return m_rst || !have_acc || (P_IDLE != 0 && n >= t_idle + P_IDLE);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rst = 1'b1; have_acc = 1'b0; m_d = 8'h00; m_rs = 1'b0; m_rstn = 1'b0;
    end else begin
      bit acc, was_off;
      acc     = phy_if.phy_valid && e_ready(cyc);
      was_off = e_cs_n(cyc);
      cyc++;
      m_rst  = 1'b0;
      m_rstn = !ctl;
      if (acc) begin
        have_acc = 1'b1;
        t_acc    = cyc;
        t_wl     = was_off ? cyc + P_CSS : cyc;
        t_idle   = t_wl + P_WRL + P_WRH;
        m_d      = phy_if.phy_data;
        m_rs     = phy_if.phy_rs;
      end
    end
  end

  always @(negedge clk) begin
    check("busy",  busy,  e_busy(cyc));
    check("ready", ready, e_ready(cyc));
    check("wr_n",  wr_n,  e_wr_n(cyc));
    check("cs_n",  cs_n,  e_cs_n(cyc));
    check("lcd_d", d,     m_d);
    check("lcd_rs", lrs,  m_rs);
    check("rst_n", rst_n, m_rstn);
  end

  task automatic send(input logic [7:0] dv, input logic rv);
    bit got;
    phy_if.phy_data  = dv;
    phy_if.phy_rs    = rv;
    phy_if.phy_valid = 1'b1;
    for (int k = 0; k < 64; k++) begin
      got = ready;
      @(negedge clk);
      if (got) begin
        phy_if.phy_valid = 1'b0;
        return;
      end
    end
    phy_if.phy_valid = 1'b0;
    n_cmp++; n_bad++;
    $display("FAIL send_timeout: ready never seen for byte %0h", dv);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("wait_ready", ready, 1'b1);
  endtask

  initial begin
    int n, falls, last, sent;
    logic pw, pr, pv;
    logic [4:0] wr_pat, rdy_pat;
    phy_if.phy_valid = 1'b0;
    phy_if.phy_data  = 8'h00;
    phy_if.phy_rs    = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1'b0);
    check("rst_cs", cs_n, 1'b1);
    check("rst_wr", wr_n, 1'b1);
    check("rst_rstn", rst_n, 1'b0);
    check("rst_d", d, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    check("rel_ready", ready, 1'b1);

    // Byte 0x2C from OFF: one setup cycle, two low, two high, then ready.
    phy_if.phy_valid = 1'b1; phy_if.phy_data = 8'h2C; phy_if.phy_rs = 1'b0;
    @(negedge clk);
    phy_if.phy_valid = 1'b0;
    check("t1_cs", cs_n, 1'b0);
    check("t1_setup_wr", wr_n, 1'b1);
    check("t1_d", d, 8'h2C);
    check("t1_rs", lrs, 1'b0);
    wr_pat  = 5'b11100;
    rdy_pat = 5'b10000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t1_wr", wr_n, wr_pat[k]);
      check("t1_ready", ready, rdy_pat[k]);
      check("t1_cs_hold", cs_n, 1'b0);
    end

    // Four back-to-back bytes with valid held high.
    phy_if.phy_valid = 1'b1; phy_if.phy_data = 8'h11; phy_if.phy_rs = 1'b1;
    sent = 0; pr = 1'b1; pv = 1'b1; pw = 1'b1; falls = 0; last = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (pr && pv) begin
        sent++;
        if (sent < 4) phy_if.phy_data = 8'h11 + 8'(sent);
        else phy_if.phy_valid = 1'b0;
      end
      pr = ready;
      pv = phy_if.phy_valid;
      if (pw && !wr_n) begin
        if (falls > 0) check("t2_period", k - last, 5);
        falls++;
        last = k;
      end
      pw = wr_n;
      check("t2_cs", cs_n, 1'b0);
    end
    check("t2_pulses", falls, 4);

    // Idle timeout, then the next byte pays the setup cycle again.
    send(8'hA5, 1'b1);
    wait_ready();
    n = 0;
    while (!cs_n && n < 300) begin
      n++;
      @(negedge clk);
    end
    check("t3_idle_len", n, 15);
    send(8'h3C, 1'b0);
    check("t3_setup_wr", wr_n, 1'b1);
    check("t3_setup_cs", cs_n, 1'b0);
    @(negedge clk);
    check("t3_wr_low", wr_n, 1'b0);

    // Byte presented exactly on the expiry cycle.
    wait_ready();
    repeat (14) @(negedge clk);
    check("t4_cs_before", cs_n, 1'b0);
    phy_if.phy_valid = 1'b1; phy_if.phy_data = 8'h5A; phy_if.phy_rs = 1'b1;
    @(negedge clk);
    phy_if.phy_valid = 1'b0;
    check("t4_wr", wr_n, 1'b0);
    check("t4_cs", cs_n, 1'b0);
    check("t4_d", d, 8'h5A);

    // Reset during the low phase.
    wait_ready();
    send(8'h77, 1'b1);
    n = 0;
    while (wr_n && n < 16) begin
      @(negedge clk);
      n++;
    end
    #2 rst = 1'b1;
    #1;
    check("t5_wr", wr_n, 1'b1);
    check("t5_cs", cs_n, 1'b1);
    check("t5_ready", ready, 1'b0);
    check("t5_rstn", rst_n, 1'b0);
    check("t5_d", d, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t5_rel_ready", ready, 1'b1);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (!wr_n) n++;
    end
    check("t5_no_pulse", n, 0);

    // Panel reset toggled mid-write.
    send(8'hC3, 1'b0);
    ctl = 1'b1;
    @(negedge clk);
    check("t6_rstn_low", rst_n, 1'b0);
    check("t6_wr_low", wr_n, 1'b0);
    ctl = 1'b0;
    @(negedge clk);
    check("t6_rstn_high", rst_n, 1'b1);
    wait_ready();

    // Random traffic at three densities; the model checks every cycle.
    for (int seg = 0; seg < 3; seg++) begin
      for (int k = 0; k < 600; k++) begin
        @(negedge clk);
        case (seg)
          0:       phy_if.phy_valid = ($urandom % 2) == 0;
          1:       phy_if.phy_valid = ($urandom % 8) == 0;
          default: phy_if.phy_valid = ($urandom % 40) == 0;
        endcase
        phy_if.phy_data = 8'($urandom);
        phy_if.phy_rs   = 1'($urandom);
        if ($urandom % 50 == 0) ctl = ~ctl;
        if ($urandom % 500 == 0) begin
          #2 rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
        end
      end
    end
    phy_if.phy_valid = 1'b0;
    ctl = 1'b0;
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
